// File: rtl/hack_instr_fetch.sv
// Hack CPU instruction fetch from SPI flash: READ (0x03) frame, mode 0, one clk per SCK phase.
// Optional single-entry fetch cache is built when INSTR_FETCH_CACHE_EN is defined.
module hack_instr_fetch #(
    parameter int WORD_WIDTH        = 16,
    parameter int ROM_ADDRESS_WIDTH = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ROM_ADDRESS_WIDTH-1:0] pc,
    input  logic                         fetch_req,
    output logic [WORD_WIDTH-1:0]        instruction,
    output logic                         instr_valid,
    output logic                         busy,
    output logic                         rom_cs_n,
    output logic                         rom_sck,
    output logic                         rom_mosi,
    input  logic                         rom_miso
);
    localparam int         FRAME_BITS = 32 + WORD_WIDTH;
    localparam logic [7:0] LAST_HALF  = 8'(2 * FRAME_BITS - 1);
    localparam logic [7:0] DATA_HALF  = 8'd64;
    localparam logic [7:0] READ_CMD   = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-2:0]   frame_q, frame_d;
    logic [WORD_WIDTH-2:0]   data_q, data_d;
    logic [WORD_WIDTH-1:0]   instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sck_q, sck_d;
    logic                    mosi_q, mosi_d;
    logic [23:0]             byte_addr_s;
    logic [FRAME_BITS-1:0]   frame_start_s;

    // Flash addresses bytes; each instruction word spans two of them.
    assign byte_addr_s   = 24'({pc, 1'b0});
    assign frame_start_s = {READ_CMD, byte_addr_s, {WORD_WIDTH{1'b0}}};

`ifdef INSTR_FETCH_CACHE_EN
    logic [ROM_ADDRESS_WIDTH-1:0] tag_q, tag_d;
    logic [WORD_WIDTH-1:0]        cword_q, cword_d;
    logic                         cvalid_q, cvalid_d;
    logic                         hit_s;

    assign hit_s = cvalid_q && (tag_q == pc);
`endif

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        data_d  = data_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
`ifdef INSTR_FETCH_CACHE_EN
        tag_d    = tag_q;
        cword_d  = cword_q;
        cvalid_d = cvalid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
`ifdef INSTR_FETCH_CACHE_EN
                if (fetch_req && hit_s) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    instr_d = cword_q;
                end else
`endif
                if (fetch_req) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 8'd0;
                    frame_d = frame_start_s[FRAME_BITS-2:0];
                    mosi_d  = frame_start_s[FRAME_BITS-1];
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
`ifdef INSTR_FETCH_CACHE_EN
                    tag_d    = pc;
                    cvalid_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                // Even half-count: SCK rises. Odd: SCK falls and the next bit is presented.
                if (!cnt_q[0]) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d   = 1'b0;
                    mosi_d  = frame_q[FRAME_BITS-2];
                    frame_d = {frame_q[FRAME_BITS-3:0], 1'b0};
                    if (cnt_q >= DATA_HALF) begin
                        data_d = {data_q[WORD_WIDTH-3:0], rom_miso};
                    end else begin
                        data_d = data_q;
                    end
                    if (cnt_q == LAST_HALF) begin
                        state_d = ST_DONE;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        valid_d = 1'b1;
                        instr_d = {data_q, rom_miso};
`ifdef INSTR_FETCH_CACHE_EN
                        cword_d  = {data_q, rom_miso};
                        cvalid_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Fetch state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            frame_q <= {(FRAME_BITS-1){1'b0}};
            data_q  <= {(WORD_WIDTH-1){1'b0}};
            instr_q <= {WORD_WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

`ifdef INSTR_FETCH_CACHE_EN
    // Single-entry cache registers; the tag is claimed at frame start, validated at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q    <= {ROM_ADDRESS_WIDTH{1'b0}};
            cword_q  <= {WORD_WIDTH{1'b0}};
            cvalid_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            cword_q  <= cword_d;
            cvalid_q <= cvalid_d;
        end
    end
`endif

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign rom_cs_n    = cs_n_q;
    assign rom_sck     = sck_q;
    assign rom_mosi    = mosi_q;

endmodule

// File: tb/tb_hack_instr_fetch.sv
// Self-checking bench for hack_instr_fetch: transaction-level timeline model plus randomized traffic.
module tb_hack_instr_fetch;
    localparam int WW = 16;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          fetch_req;
    logic [WW-1:0] instruction;
    logic          instr_valid;
    logic          busy;
    logic          rom_cs_n;
    logic          rom_sck;
    logic          rom_mosi;
    logic          rom_miso;

    hack_instr_fetch #(.WORD_WIDTH(WW), .ROM_ADDRESS_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .rom_cs_n    (rom_cs_n),
        .rom_sck     (rom_sck),
        .rom_mosi    (rom_mosi),
        .rom_miso    (rom_miso)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Flash contents, created lazily with random words.
    logic [15:0] flash_mem [int];

    // Model: m_k counts cycles since the accepting edge of the fetch in flight.
    bit            m_active = 1'b0;
    bit            m_hit    = 1'b0;
    int            m_k      = 0;
    logic [AW-1:0] m_pc     = '0;
    logic [15:0]   m_data   = 16'h0000;
    logic [15:0]   m_instr  = 16'h0000;
`ifdef INSTR_FETCH_CACHE_EN
    bit            c_valid  = 1'b0;
    logic [AW-1:0] c_tag    = '0;
    logic [15:0]   c_word   = 16'h0000;
`endif

    int          valid_cnt  = 0;
    int          accept_cnt = 0;
    int          cs_low_cnt = 0;
    int          cyc        = 0;
    logic [31:0] mosi_cap   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] flash_word(input logic [AW-1:0] a);
        if (!flash_mem.exists(int'(a))) flash_mem[int'(a)] = 16'($urandom);
        return flash_mem[int'(a)];
    endfunction

    function automatic int last_k();
        return m_hit ? 1 : 97;
    endfunction

    function automatic bit spi_on();
        return m_active && !m_hit && (m_k <= 96);
    endfunction

    function automatic logic exp_mosi();
        logic [47:0] f;
        int          idx;
        f   = {8'h03, 8'h00, m_pc, 1'b0, 16'h0000};
        idx = (m_k - 1) / 2;
        return spi_on() ? f[47 - idx] : 1'b0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_hit    = 1'b0;
        m_k      = 0;
        m_instr  = 16'h0000;
`ifdef INSTR_FETCH_CACHE_EN
        c_valid  = 1'b0;
`endif
    endtask

    task automatic model_edge();
        if (reset === 1'b1) begin
            if (m_active) begin
                if (m_k == last_k()) begin
                    m_active = 1'b0;
                end else begin
                    m_k++;
                    if (m_k == last_k()) begin
                        m_instr = m_data;
`ifdef INSTR_FETCH_CACHE_EN
                        c_valid = 1'b1;
                        c_tag   = m_pc;
                        c_word  = m_data;
`endif
                    end
                end
            end else if (fetch_req === 1'b1) begin
                accept_cnt++;
                m_active = 1'b1;
                m_k      = 1;
                m_pc     = pc;
`ifdef INSTR_FETCH_CACHE_EN
                m_hit    = c_valid && (c_tag == pc);
`else
                m_hit    = 1'b0;
`endif
                m_data   = flash_word(pc);
                if (m_hit) m_instr = m_data;
            end
        end
    endtask

    // Flash drives the data bit for the whole bit period; junk elsewhere.
    task automatic drive_miso();
        int idx;
        idx = (m_k - 1) / 2;
        if (spi_on() && idx >= 32) rom_miso = m_data[47 - idx];
        else rom_miso = 1'($urandom_range(0, 1));
    endtask

    task automatic compare_all();
        chk("busy",        {31'd0, busy},        {31'd0, m_active});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_active && m_k == last_k())});
        chk("rom_cs_n",    {31'd0, rom_cs_n},    {31'd0, !spi_on()});
        chk("rom_sck",     {31'd0, rom_sck},     {31'd0, (spi_on() && (m_k % 2 == 0))});
        chk("rom_mosi",    {31'd0, rom_mosi},    {31'd0, exp_mosi()});
        chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
        if (instr_valid === 1'b1) valid_cnt++;
        if (rom_cs_n === 1'b0) cs_low_cnt++;
        if (spi_on() && (m_k % 2 == 0) && m_k <= 64) mosi_cap = {mosi_cap[30:0], rom_mosi};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        drive_miso();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic run_fetch(input logic [AW-1:0] pcv, input int exp_lat);
        int n;
        mosi_cap  = 32'h0;
        pc        = pcv;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 1;
        while (instr_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("latency", n, exp_lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words[$];
        int          times[$];
        int          v0;
        int          a0;
        int          c0;
        int          g;

        reset     = 1'b1;
        pc        = '0;
        fetch_req = 1'b0;
        rom_miso  = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_cs_n",  {31'd0, rom_cs_n},    32'd1);
        chk("rst_sck",   {31'd0, rom_sck},     32'd0);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // Basic fetch
        flash_mem[5] = 16'hEC10;
        run_fetch(15'h0005, 97);
        chk("basic_mosi_frame", mosi_cap, 32'h0300000A);
        chk("basic_word", {16'd0, instruction}, 32'h0000EC10);
        chk("basic_busy_at_valid", {31'd0, busy}, 32'd1);
        step();
        chk("basic_busy_after", {31'd0, busy}, 32'd0);

        // Max address
        flash_mem[32'h7FFF] = 16'h0001;
        run_fetch(15'h7FFF, 97);
        chk("max_mosi_frame", mosi_cap, 32'h0300FFFE);
        chk("max_word", {16'd0, instruction}, 32'h00000001);
        step();

        // Request during an active fetch is dropped
        v0 = valid_cnt;
        pc = 15'h0123;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        g = 0;
        while (m_k < 39 && g < 200) begin
            step();
            g++;
        end
        pc = 15'h0456;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        repeat (80) step();
        chk("ignored_valid_count", valid_cnt - v0, 32'd1);
        chk("ignored_word", {16'd0, instruction}, {16'd0, flash_word(15'h0123)});
        chk("ignored_busy_idle", {31'd0, busy}, 32'd0);

        // Back-to-back with request held high; pc moves right after acceptance
        a0 = accept_cnt;
        v0 = valid_cnt;
        pc = 15'h0001;
        fetch_req = 1'b1;
        g = 0;
        while (valid_cnt < v0 + 2 && g < 400) begin
            step();
            g++;
            if (instr_valid === 1'b1) begin
                words.push_back(instruction);
                times.push_back(cyc);
            end
            if (accept_cnt >= a0 + 2) fetch_req = 1'b0;
            else if (accept_cnt == a0 + 1) pc = 15'h0002;
        end
        fetch_req = 1'b0;
        chk("b2b_count", words.size(), 32'd2);
        if (words.size() == 2) begin
            chk("b2b_word0", {16'd0, words[0]}, {16'd0, flash_word(15'h0001)});
            chk("b2b_word1", {16'd0, words[1]}, {16'd0, flash_word(15'h0002)});
            chk("b2b_gap", times[1] - times[0], 32'd98);
        end
        step();

        // Reset abort at cycle 50
        pc = 15'h02AA;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        g = 0;
        while (m_k < 50 && g < 200) begin
            step();
            g++;
        end
        reset = 1'b0;
        #1;
        model_reset();
        chk("abort_cs_n",  {31'd0, rom_cs_n},    32'd1);
        chk("abort_busy",  {31'd0, busy},        32'd0);
        chk("abort_instr", {16'd0, instruction}, 32'd0);
        compare_all();
        v0 = valid_cnt;
        repeat (2) step();
        reset = 1'b1;
        repeat (120) step();
        chk("abort_no_valid", valid_cnt - v0, 32'd0);
        run_fetch(15'h02AA, 97);
        chk("after_abort_word", {16'd0, instruction}, {16'd0, flash_word(15'h02AA)});
        step();

`ifdef INSTR_FETCH_CACHE_EN
        flash_mem[3] = 16'h1234;
        run_fetch(15'h0003, 97);
        step();
        c0 = cs_low_cnt;
        run_fetch(15'h0003, 1);
        chk("cache_hit_word", {16'd0, instruction}, 32'h00001234);
        step();
        chk("cache_hit_no_cs", cs_low_cnt - c0, 32'd0);
        run_fetch(15'h0004, 97);
        step();
`else
        c0 = cs_low_cnt;
        run_fetch(15'h0003, 97);
        chk("refetch_cs_low", cs_low_cnt - c0, 32'd96);
        step();
`endif

        // Randomized traffic on a small pc range
        for (int i = 0; i < 2500; i++) begin
            pc        = 15'($urandom_range(0, 7));
            fetch_req = ($urandom_range(0, 3) == 0);
            step();
        end
        fetch_req = 1'b0;
        repeat (200) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
